// File: rtl/game_pkg.sv
// Shared definitions for the player controller: state encoding, action durations
// and the jump vertical-velocity table.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    JUMP    = 3'd2,
    ATTACK  = 3'd3,
    SPECIAL = 3'd4,
    HURT    = 3'd5,
    KO      = 3'd6
  } player_state_e;

  localparam int JUMP_LEN    = 32;
  localparam int ATK_LEN     = 24;
  localparam int SPECIAL_LEN = 16;

  localparam int LUNGE_FIRST = 4;
  localparam int LUNGE_LAST  = 6;
  localparam int CHAIN_OPEN  = 16;

  // One dy per 8-frame quarter of the jump: fast rise, slow apex, fast fall.
  function automatic logic signed [9:0] jump_dy(input logic [1:0] seg);
    logic signed [9:0] dy;
    dy = '0;
    case (seg)
      2'd0: dy = -10'sd6;
      2'd1: dy = -10'sd2;
      2'd2: dy = 10'sd2;
      2'd3: dy = 10'sd6;
      default: dy = '0;
    endcase
    return dy;
  endfunction

endpackage

// File: rtl/key_matcher.sv
// Reports whether any of the packed keyboard slots holds the given binding.
module key_matcher #(
  parameter int         NUM_KEYS = 6,
  parameter logic [7:0] BINDING  = 8'd0
) (
  input  logic [NUM_KEYS*8-1:0] keycodes,
  output logic                  pressed
);

  always_comb begin
    pressed = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keycodes[i*8 +: 8] == BINDING) pressed = 1'b1;
    end
  end

endmodule

// File: rtl/player_ctrl.sv
// Per-frame fighter controller: key decode, action state machine, position,
// hit points and the special-attack summon pulse.
module player_ctrl
  import game_pkg::*;
#(
  parameter int         NUM_KEYS    = 6,
  parameter logic [7:0] KEY_LEFT    = 8'd80,
  parameter logic [7:0] KEY_RIGHT   = 8'd79,
  parameter logic [7:0] KEY_JUMP    = 8'd82,
  parameter logic [7:0] KEY_ATK     = 8'd90,
  parameter logic [7:0] KEY_SPECIAL = 8'd91,
  parameter logic [9:0] X_START     = 10'd80,
  parameter logic [9:0] Y_GROUND    = 10'd300,
  parameter logic [9:0] X_MIN       = 10'd10,
  parameter logic [9:0] X_MAX       = 10'd550,
  parameter logic [9:0] HP_MAX      = 10'd150,
  parameter logic [9:0] WALK_STEP   = 10'd3,
  parameter logic [9:0] HURT_LEN    = 10'd12,
  parameter int         COMBO_MAX   = 3
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [NUM_KEYS*8-1:0] keycodes,
  input  logic                  enable,
  input  logic [9:0]            damage,
  input  logic [3:0]            combo,
  input  logic                  ball_ready,
  output logic [9:0]            player_x,
  output logic [9:0]            player_y,
  output logic [9:0]            player_hp,
  output logic                  face,
  output logic                  summon_ball,
  output logic [2:0]            state,
  output logic [6:0]            frame,
  output logic [2:0]            hit,
  output logic                  ko
);

  localparam logic [6:0] JUMP_LAST    = 7'(JUMP_LEN - 1);
  localparam logic [6:0] ATK_LAST     = 7'(ATK_LEN - 1);
  localparam logic [6:0] SPECIAL_LAST = 7'(SPECIAL_LEN - 1);
  localparam logic [6:0] LUNGE_LO     = 7'(LUNGE_FIRST);
  localparam logic [6:0] LUNGE_HI     = 7'(LUNGE_LAST);
  localparam logic [6:0] CHAIN_LO     = 7'(CHAIN_OPEN);
  localparam logic [9:0] HURT_LAST    = HURT_LEN - 10'd1;
  localparam logic signed [10:0] STEP = $signed({1'b0, WALK_STEP});

  logic left_raw, right_raw, jump_raw, atk_raw, special_raw;
  logic left_q, right_q, jump_q, atk_q, special_q;

  player_state_e cur_state;
  logic          atk_buf;

  logic [9:0]        hp_next;
  logic              ko_now, hurt_now, walk_move, walk_sel, chain_ok;
  logic signed [10:0] dx, x_sum;
  logic [9:0]        x_next, y_jump;
  logic [6:0]        frame_inc;

  key_matcher #(.NUM_KEYS(NUM_KEYS), .BINDING(KEY_LEFT))    u_left    (.keycodes(keycodes), .pressed(left_raw));
  key_matcher #(.NUM_KEYS(NUM_KEYS), .BINDING(KEY_RIGHT))   u_right   (.keycodes(keycodes), .pressed(right_raw));
  key_matcher #(.NUM_KEYS(NUM_KEYS), .BINDING(KEY_JUMP))    u_jump    (.keycodes(keycodes), .pressed(jump_raw));
  key_matcher #(.NUM_KEYS(NUM_KEYS), .BINDING(KEY_ATK))     u_atk     (.keycodes(keycodes), .pressed(atk_raw));
  key_matcher #(.NUM_KEYS(NUM_KEYS), .BINDING(KEY_SPECIAL)) u_special (.keycodes(keycodes), .pressed(special_raw));

  assign state     = cur_state;
  assign hp_next   = (damage > player_hp) ? 10'd0 : player_hp - damage;
  assign ko_now    = (cur_state == KO) || (hp_next == 10'd0);
  assign hurt_now  = (damage != 10'd0);
  assign walk_move = left_q ^ right_q;
  assign walk_sel  = walk_move && !jump_q && !(special_q && ball_ready) && !atk_q;
  assign frame_inc = (frame == 7'd127) ? frame : frame + 7'd1;
  assign y_jump    = player_y + jump_dy(frame[4:3]);
  assign chain_ok  = (atk_buf || atk_q) && (combo != 4'd0) && (int'(hit) < COMBO_MAX - 1);

  // Every horizontal contribution is summed first so one clamp covers them all;
  // damage and KO frames freeze the fighter.
  always_comb begin
    dx = '0;
    if (!ko_now && !hurt_now) begin
      case (cur_state)
        IDLE, WALK: if (walk_sel) dx = left_q ? -STEP : STEP;
        JUMP:       if (walk_move) dx = left_q ? -STEP : STEP;
        ATTACK:     if (frame >= LUNGE_LO && frame <= LUNGE_HI) dx = face ? -11'sd1 : 11'sd1;
        HURT:       dx = face ? 11'sd2 : -11'sd2;
        default:    dx = '0;
      endcase
    end
    x_sum = $signed({1'b0, player_x}) + dx;
    if (x_sum < $signed({1'b0, X_MIN}))      x_next = X_MIN;
    else if (x_sum > $signed({1'b0, X_MAX})) x_next = X_MAX;
    else                                     x_next = x_sum[9:0];
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      cur_state   <= IDLE;
      frame       <= '0;
      hit         <= '0;
      player_x    <= X_START;
      player_y    <= Y_GROUND;
      player_hp   <= HP_MAX;
      face        <= 1'b0;
      summon_ball <= 1'b0;
      ko          <= 1'b0;
      atk_buf     <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      jump_q      <= 1'b0;
      atk_q       <= 1'b0;
      special_q   <= 1'b0;
    end else begin
      left_q      <= left_raw & enable;
      right_q     <= right_raw & enable;
      jump_q      <= jump_raw & enable;
      atk_q       <= atk_raw & enable;
      special_q   <= special_raw & enable;
      player_hp   <= hp_next;
      player_x    <= x_next;
      summon_ball <= 1'b0;

      if (cur_state == KO) begin
        frame <= frame_inc;
      end else if (hp_next == 10'd0) begin
        cur_state <= KO;
        frame     <= '0;
        hit       <= '0;
        atk_buf   <= 1'b0;
        ko        <= 1'b1;
      end else if (hurt_now) begin
        cur_state <= HURT;
        frame     <= '0;
        hit       <= '0;
        atk_buf   <= 1'b0;
        player_y  <= Y_GROUND;
      end else begin
        case (cur_state)
          IDLE, WALK: begin
            if (jump_q) begin
              cur_state <= JUMP;
              frame     <= '0;
            end else if (special_q && ball_ready) begin
              cur_state   <= SPECIAL;
              frame       <= '0;
              summon_ball <= 1'b1;
            end else if (atk_q) begin
              cur_state <= ATTACK;
              frame     <= '0;
              hit       <= '0;
              atk_buf   <= 1'b0;
            end else if (walk_move) begin
              cur_state <= WALK;
              face      <= left_q;
              frame     <= (cur_state == WALK) ? frame_inc : 7'd0;
            end else begin
              cur_state <= IDLE;
              frame     <= (cur_state == IDLE) ? frame_inc : 7'd0;
            end
          end
          JUMP: begin
            if (walk_move) face <= left_q;
            if (frame == JUMP_LAST) begin
              cur_state <= IDLE;
              frame     <= '0;
              player_y  <= Y_GROUND;
            end else begin
              player_y <= y_jump;
              frame    <= frame_inc;
            end
          end
          ATTACK: begin
            // A press anywhere in the late window is remembered until the chain decision.
            if (frame >= CHAIN_LO && atk_q) atk_buf <= 1'b1;
            if (frame == ATK_LAST) begin
              atk_buf <= 1'b0;
              frame   <= '0;
              if (chain_ok) begin
                hit <= hit + 3'd1;
              end else begin
                cur_state <= IDLE;
                hit       <= '0;
              end
            end else begin
              frame <= frame_inc;
            end
          end
          SPECIAL: begin
            if (frame == SPECIAL_LAST) begin
              cur_state <= IDLE;
              frame     <= '0;
            end else begin
              frame <= frame_inc;
            end
          end
          HURT: begin
            if ({3'b000, frame} == HURT_LAST) begin
              cur_state <= IDLE;
              frame     <= '0;
            end else begin
              frame <= frame_inc;
            end
          end
          default: begin
            cur_state <= IDLE;
            frame     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: a vector table for walking/enable/clamp behaviour plus
// hand sequences for jump, hurt, KO, combo and special timing.
module tb_player_ctrl;

  localparam logic [7:0] B_LEFT = 8'd80, B_RIGHT = 8'd79, B_JUMP = 8'd82, B_ATK = 8'd90, B_SPEC = 8'd91;
  localparam logic [4:0] M_NONE = 5'd0, M_LEFT = 5'd1, M_RIGHT = 5'd2, M_JUMP = 5'd4, M_ATK = 5'd8, M_SPEC = 5'd16;
  localparam int S_IDLE = 0, S_WALK = 1, S_JUMP = 2, S_ATK = 3, S_SPEC = 4, S_HURT = 5, S_KO = 6;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic        reset_edge = 1'b0;
  logic [47:0] keycodes = '0;
  logic        enable = 1'b1;
  logic [9:0]  damage = '0;
  logic [3:0]  combo = '0;
  logic        ball_ready = 1'b0;

  logic [9:0] player_x, player_y, player_hp;
  logic       face, summon_ball, ko;
  logic [2:0] state, hit;
  logic [6:0] frame;

  logic [9:0] edge_x, edge_y, edge_hp;
  logic       edge_face, edge_summon, edge_ko;
  logic [2:0] edge_state, edge_hit;
  logic [6:0] edge_frame;

  player_ctrl u_dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycodes(keycodes), .enable(enable),
    .damage(damage), .combo(combo), .ball_ready(ball_ready),
    .player_x(player_x), .player_y(player_y), .player_hp(player_hp), .face(face),
    .summon_ball(summon_ball), .state(state), .frame(frame), .hit(hit), .ko(ko)
  );

  player_ctrl #(.X_START(10'd549)) u_dut_edge (
    .frame_clk(frame_clk), .Reset(reset_edge), .keycodes(keycodes), .enable(enable),
    .damage(damage), .combo(combo), .ball_ready(ball_ready),
    .player_x(edge_x), .player_y(edge_y), .player_hp(edge_hp), .face(edge_face),
    .summon_ball(edge_summon), .state(edge_state), .frame(edge_frame), .hit(edge_hit), .ko(edge_ko)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] keys;
    logic       en;
    logic       ball;
    int         frames;
    int         x, y, hp, face, st;
  } vec_t;

  typedef struct {
    string name;
    int    x, y, hp, face, st, hit, ko;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;

  function automatic logic [47:0] make_keys(input logic [4:0] m);
    logic [47:0] k;
    k = '0;
    if (m[0]) k[47:40] = B_LEFT;
    if (m[1]) k[7:0]   = B_RIGHT;
    if (m[2]) k[23:16] = B_JUMP;
    if (m[3]) k[31:24] = B_ATK;
    if (m[4]) k[15:8]  = B_SPEC;
    return k;
  endfunction

  function automatic vec_t mkv(input string n, input logic rst, input logic [4:0] keys, input logic en,
                               input logic ball, input int frames, input int x, input int face, input int st);
    vec_t v;
    v.name = n; v.rst = rst; v.keys = keys; v.en = en; v.ball = ball; v.frames = frames;
    v.x = x; v.y = 300; v.hp = 150; v.face = face; v.st = st;
    return v;
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic pushExpect(input string n, input int x, input int y, input int hp, input int f,
                            input int st, input int h, input int k);
    exp_t e;
    e.name = n; e.x = x; e.y = y; e.hp = hp; e.face = f; e.st = st; e.hit = h; e.ko = k;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkField("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkField({e.name, ".x"},     player_x,  e.x);
      checkField({e.name, ".y"},     player_y,  e.y);
      checkField({e.name, ".hp"},    player_hp, e.hp);
      checkField({e.name, ".face"},  face,      e.face);
      checkField({e.name, ".state"}, state,     e.st);
      checkField({e.name, ".hit"},   hit,       e.hit);
      checkField({e.name, ".ko"},    ko,        e.ko);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    Reset      = !v.rst;
    keycodes   = make_keys(v.keys);
    enable     = v.en;
    damage     = '0;
    combo      = '0;
    ball_ready = v.ball;
    pushExpect(v.name, v.x, v.y, v.hp, v.face, v.st, 0, 0);
    repeat (v.frames) tick();
  endtask

  task automatic doReset();
    Reset = 1'b0; keycodes = '0; damage = '0; combo = '0; ball_ready = 1'b0; enable = 1'b1;
    tick(); tick();
    Reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int miny, pulses;

    vecs.push_back(mkv("reset",        1'b1, M_NONE,           1'b1, 1'b0, 2,  80,  0, S_IDLE));
    vecs.push_back(mkv("right_walk",   1'b0, M_RIGHT,          1'b1, 1'b0, 11, 110, 0, S_WALK));
    vecs.push_back(mkv("right_stop",   1'b0, M_NONE,           1'b1, 1'b0, 2,  113, 0, S_IDLE));
    vecs.push_back(mkv("both_held",    1'b0, M_LEFT | M_RIGHT, 1'b1, 1'b0, 5,  113, 0, S_IDLE));
    vecs.push_back(mkv("left_walk",    1'b0, M_LEFT,           1'b1, 1'b0, 4,  104, 1, S_WALK));
    vecs.push_back(mkv("left_stop",    1'b0, M_NONE,           1'b1, 1'b0, 2,  101, 1, S_IDLE));
    vecs.push_back(mkv("disabled",     1'b0, M_RIGHT,          1'b0, 1'b0, 4,  101, 1, S_IDLE));
    vecs.push_back(mkv("left_to_11",   1'b0, M_LEFT,           1'b1, 1'b0, 31, 11,  1, S_WALK));
    vecs.push_back(mkv("left_clamp",   1'b0, M_LEFT,           1'b1, 1'b0, 3,  10,  1, S_WALK));
    vecs.push_back(mkv("clamp_stop",   1'b0, M_NONE,           1'b1, 1'b0, 2,  10,  1, S_IDLE));
    vecs.push_back(mkv("spec_no_ball", 1'b0, M_SPEC,           1'b1, 1'b0, 4,  10,  1, S_IDLE));
    vecs.push_back(mkv("spec_release", 1'b0, M_NONE,           1'b1, 1'b0, 2,  10,  1, S_IDLE));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Single jump press: full trajectory and landing
    doReset();
    keycodes = make_keys(M_JUMP); tick();
    keycodes = '0; tick();
    pushExpect("jump_entry", 80, 300, 150, 0, S_JUMP, 0, 0); checkOutput();
    checkField("jump_entry.frame", frame, 0);
    miny = 300;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (int'(player_y) < miny) miny = int'(player_y);
      if (i == 8) checkField("jump_y_after8", player_y, 252);
      if (i == 16) begin
        checkField("jump_apex_y", player_y, 236);
        checkField("jump_apex_frame", frame, 16);
      end
    end
    pushExpect("jump_land", 80, 300, 150, 0, S_IDLE, 0, 0); checkOutput();
    checkField("jump_min_y", miny, 236);

    // Damage mid-jump aborts into HURT with knockback
    doReset();
    keycodes = make_keys(M_JUMP); tick();
    keycodes = '0; tick();
    repeat (5) tick();
    checkField("prehurt_y", player_y, 270);
    damage = 10'd20; tick(); damage = '0;
    pushExpect("hurt_entry", 80, 300, 130, 0, S_HURT, 0, 0); checkOutput();
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) begin pushExpect("hurt_f1", 78, 300, 130, 0, S_HURT, 0, 0); checkOutput(); end
      if (i == 11) begin
        pushExpect("hurt_f11", 58, 300, 130, 0, S_HURT, 0, 0); checkOutput();
        checkField("hurt_f11.frame", frame, 11);
      end
      if (i == 12) begin pushExpect("hurt_exit", 56, 300, 130, 0, S_IDLE, 0, 0); checkOutput(); end
    end

    // Lethal damage: KO ignores keys and pulses until reset
    damage = 10'd200; tick(); damage = '0;
    pushExpect("ko_entry", 56, 300, 0, 0, S_KO, 0, 1); checkOutput();
    keycodes = make_keys(M_RIGHT | M_JUMP | M_SPEC); ball_ready = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      if (summon_ball) pulses++;
    end
    pushExpect("ko_hold", 56, 300, 0, 0, S_KO, 0, 1); checkOutput();
    checkField("ko_no_summon", pulses, 0);
    Reset = 1'b0; tick();
    pushExpect("ko_reset", 80, 300, 150, 0, S_IDLE, 0, 0); checkOutput();
    checkField("ko_reset.summon", summon_ball, 0);

    // ATK held with combo enabled: three chained hits
    doReset();
    keycodes = make_keys(M_ATK); combo = 4'd1;
    tick(); tick();
    pushExpect("atk_entry", 80, 300, 150, 0, S_ATK, 0, 0); checkOutput();
    for (int i = 1; i <= 72; i++) begin
      tick();
      if (i == 7) checkField("atk_lunge_x", player_x, 83);
      if (i == 24) begin
        pushExpect("atk_hit1", 83, 300, 150, 0, S_ATK, 1, 0); checkOutput();
        checkField("atk_hit1.frame", frame, 0);
      end
      if (i == 48) begin pushExpect("atk_hit2", 86, 300, 150, 0, S_ATK, 2, 0); checkOutput(); end
      if (i == 72) begin pushExpect("atk_done", 89, 300, 150, 0, S_IDLE, 0, 0); checkOutput(); end
    end

    // ATK held without combo permission: one hit only
    doReset();
    keycodes = make_keys(M_ATK); combo = 4'd0;
    tick(); tick();
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 23) begin
        checkField("atk_single.f23_state", state, S_ATK);
        checkField("atk_single.f23_frame", frame, 23);
      end
    end
    pushExpect("atk_single_end", 83, 300, 150, 0, S_IDLE, 0, 0); checkOutput();

    // Special: blocked without ball, then a single summon pulse
    doReset();
    keycodes = make_keys(M_SPEC); ball_ready = 1'b0;
    repeat (4) tick();
    pushExpect("spec_blocked", 80, 300, 150, 0, S_IDLE, 0, 0); checkOutput();
    checkField("spec_blocked.summon", summon_ball, 0);
    ball_ready = 1'b1; keycodes = '0; tick();
    checkField("spec_entry.summon", summon_ball, 1);
    checkField("spec_entry.state", state, S_SPEC);
    checkField("spec_entry.frame", frame, 0);
    pulses = int'(summon_ball);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (summon_ball) pulses++;
      if (i == 15) checkField("spec_f15.state", state, S_SPEC);
      if (i == 16) checkField("spec_exit.state", state, S_IDLE);
    end
    checkField("spec_pulse_count", pulses, 1);
    ball_ready = 1'b0;

    // Right-hand clamp on the instance that starts at x=549
    keycodes = make_keys(M_RIGHT); reset_edge = 1'b0;
    tick();
    checkField("edge_reset_x", edge_x, 549);
    reset_edge = 1'b1;
    tick(); tick();
    checkField("edge_clamp_x", edge_x, 550);
    checkField("edge_clamp_state", edge_state, S_WALK);
    repeat (4) tick();
    checkField("edge_hold_x", edge_x, 550);
    checkField("edge_hold_face", edge_face, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
